// File: rtl/dma_uart_pkg.sv
// Shared constants and types for the DMA UART command link (transmit and receive sides).
package dma_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 10416;
    localparam int FRAME_BYTES      = 3;

    localparam int WE_BIT   = 7;
    localparam int ADDR_MSB = 6;
    localparam int ADDR_W   = ADDR_MSB + 1;
    localparam int DAT_W    = 18;

    localparam int HI_MSB = 17;
    localparam int HI_LSB = 10;
    localparam int LO_MSB = 9;
    localparam int LO_LSB = 2;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
    typedef enum logic [1:0] {F_CMD, F_HI, F_LO} frame_state_t;

    // The link drops dat[1:0]; the receiver restores them as zero.
    function automatic logic [DAT_W-1:0] pack_dat(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo, 2'b00};
    endfunction

endpackage

// File: rtl/dma_uart_rx_byte.sv
// 8N1 byte deserialiser with 2-flop input synchroniser.
// Latency: byte_valid/byte_err one cycle after the stop-bit sample edge.
// Backpressure: none; the consumer must take each one-cycle pulse.
module dma_uart_rx_byte
    import dma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_byte_err,
    output logic       o_byte_busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    r_sync;
    byte_state_t   r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [7:0]    r_shift, w_shift_n;
    logic          r_valid, w_valid_n;
    logic          r_err, w_err_n;
    logic          w_rxs;

    assign w_rxs = r_sync[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= 2'b11;
            r_state <= B_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_rxd};
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
            r_valid <= w_valid_n;
            r_err   <= w_err_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CW'(1);
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_valid_n = 1'b0;
        w_err_n   = 1'b0;
        case (r_state)
            B_IDLE: begin
                w_cnt_n = '0;
                if (!w_rxs) w_state_n = B_START;
            end
            B_START: begin
                // A start bit that is gone by mid-bit was line noise.
                if (r_cnt == HALF_END) begin
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = w_rxs ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_n   = '0;
                    w_shift_n = {w_rxs, r_shift[7:1]};
                    w_bit_n   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_n = B_STOP;
                end
            end
            B_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_n   = '0;
                    w_valid_n = w_rxs;
                    w_err_n   = !w_rxs;
                    w_state_n = B_IDLE;
                end
            end
            default: w_state_n = B_IDLE;
        endcase
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_valid;
    assign o_byte_err   = r_err;
    assign o_byte_busy  = (r_state != B_IDLE);

endmodule

// File: rtl/dma_uart_rx.sv
// UART command receiver: decodes 3-byte write / 1-byte read frames into DMA strobes.
// Latency: we/re asserted in the second cycle after the final stop-bit sample edge.
// Backpressure: none; strobes and frame_err are single-cycle pulses.
module dma_uart_rx
    import dma_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
    parameter int FRAME_TIMEOUT = 208320
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rxd,
    output logic [DAT_W-1:0]    dma_dat_r,
    output logic [ADDR_MSB:0]   dma_dat_addr,
    output logic                we,
    output logic                re,
    output logic                busy,
    output logic                frame_err
);

    localparam int TW = (FRAME_TIMEOUT > 2) ? $clog2(FRAME_TIMEOUT) : 1;
    localparam bit TO_EN = (FRAME_TIMEOUT > 0);
    localparam logic [TW-1:0] TO_END = TW'((FRAME_TIMEOUT > 0) ? FRAME_TIMEOUT - 1 : 0);

    logic [7:0]       w_byte;
    logic             w_byte_valid;
    logic             w_byte_err;
    logic             w_byte_busy;

    frame_state_t     r_fstate, w_fstate_n;
    logic [ADDR_MSB:0] r_cmd_addr, w_cmd_addr_n;
    logic [7:0]       r_hi, w_hi_n;
    logic [TW-1:0]    r_tcnt, w_tcnt_n;
    logic [DAT_W-1:0] r_dat, w_dat_n;
    logic [ADDR_MSB:0] r_addr, w_addr_n;
    logic             r_we, w_we_n;
    logic             r_re, w_re_n;
    logic             r_ferr, w_ferr_n;

    dma_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_rxd        (uart_rxd),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_byte_err   (w_byte_err),
        .o_byte_busy  (w_byte_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fstate   <= F_CMD;
            r_cmd_addr <= '0;
            r_hi       <= '0;
            r_tcnt     <= '0;
            r_dat      <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_re       <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_fstate   <= w_fstate_n;
            r_cmd_addr <= w_cmd_addr_n;
            r_hi       <= w_hi_n;
            r_tcnt     <= w_tcnt_n;
            r_dat      <= w_dat_n;
            r_addr     <= w_addr_n;
            r_we       <= w_we_n;
            r_re       <= w_re_n;
            r_ferr     <= w_ferr_n;
        end
    end

    always_comb begin
        w_fstate_n   = r_fstate;
        w_cmd_addr_n = r_cmd_addr;
        w_hi_n       = r_hi;
        w_tcnt_n     = (r_fstate == F_CMD) ? '0 : r_tcnt + TW'(1);
        w_dat_n      = r_dat;
        w_addr_n     = r_addr;
        w_we_n       = 1'b0;
        w_re_n       = 1'b0;
        w_ferr_n     = 1'b0;
        if (w_byte_err) begin
            w_ferr_n   = 1'b1;
            w_fstate_n = F_CMD;
            w_tcnt_n   = '0;
        end else if (w_byte_valid) begin
            w_tcnt_n = '0;
            case (r_fstate)
                F_CMD: begin
                    w_cmd_addr_n = w_byte[ADDR_MSB:0];
                    if (w_byte[WE_BIT]) begin
                        w_fstate_n = F_HI;
                    end else begin
                        w_re_n   = 1'b1;
                        w_addr_n = w_byte[ADDR_MSB:0];
                    end
                end
                F_HI: begin
                    w_hi_n     = w_byte;
                    w_fstate_n = F_LO;
                end
                F_LO: begin
                    // Write address is only published together with its data.
                    w_dat_n    = pack_dat(r_hi, w_byte);
                    w_addr_n   = r_cmd_addr;
                    w_we_n     = 1'b1;
                    w_fstate_n = F_CMD;
                end
                default: w_fstate_n = F_CMD;
            endcase
        end else if (TO_EN && (r_fstate != F_CMD) && (r_tcnt == TO_END)) begin
            w_ferr_n   = 1'b1;
            w_fstate_n = F_CMD;
            w_tcnt_n   = '0;
        end
    end

    assign dma_dat_r    = r_dat;
    assign dma_dat_addr = r_addr;
    assign we           = r_we;
    assign re           = r_re;
    assign frame_err    = r_ferr;
    assign busy         = w_byte_busy | (r_fstate != F_CMD);

endmodule

// File: tb/tb_dma_uart_rx.sv
// Directed bench for dma_uart_rx with a frame-level reference model and per-cycle compare.
module tb_dma_uart_rx;

    localparam int C = 256;
    localparam int H = C / 2;
    localparam int T = 20 * C;

    logic        clk;
    logic        reset;
    logic        uart_rxd;
    logic [17:0] dma_dat_r;
    logic [6:0]  dma_dat_addr;
    logic        we, re, busy, frame_err;

    dma_uart_rx #(.CLKS_PER_BIT(C), .FRAME_TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (uart_rxd),
        .dma_dat_r    (dma_dat_r),
        .dma_dat_addr (dma_dat_addr),
        .we           (we),
        .re           (re),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected events keyed by the cycle in which the DUT output must be high.
    // kind: 1 = write strobe, 2 = read strobe, 3 = frame error.
    int          ev_kind [int];
    logic [6:0]  ev_addr [int];
    logic [17:0] ev_dat  [int];

    int          m_state = 0;
    logic [6:0]  m_cmd   = '0;
    logic [7:0]  m_hi    = '0;
    int          pend_to = -1;
    int          rst_at  = -1;
    logic [6:0]  exp_addr = '0;
    logic [17:0] exp_dat  = '0;
    bit          chk_en   = 0;
    int          n_we = 0, n_re = 0, n_ferr = 0;
    int          kind;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Frame decoder: byte accepted at cycle a; outputs show results in that cycle.
    task automatic model_byte(input logic [7:0] b, input bit ok, input int a);
        if (pend_to >= 0) begin
            if (a >= pend_to) begin
                ev_kind[pend_to] = 3;
                m_state = 0;
            end
            pend_to = -1;
        end
        if (!ok) begin
            ev_kind[a] = 3;
            m_state = 0;
        end else if (m_state == 0) begin
            if (b[7]) begin
                m_cmd = b[6:0];
                m_state = 1;
                pend_to = a + T;
            end else begin
                ev_kind[a] = 2;
                ev_addr[a] = b[6:0];
            end
        end else if (m_state == 1) begin
            m_hi = b;
            m_state = 2;
            pend_to = a + T;
        end else begin
            ev_kind[a] = 1;
            ev_addr[a] = m_cmd;
            ev_dat[a]  = 18'(m_hi) * 1024 + 18'(b) * 4;
            m_state = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        int s;
        s = cyc;
        // 2 sync flops + idle detect, half bit, then 9 full bits to the stop sample.
        model_byte(b, stop_ok, s + 3 + H + 9 * C + 1);
        uart_rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (C) tick();
        end
        uart_rxd = stop_ok;
        repeat (C) tick();
        uart_rxd = 1'b1;
    endtask

    task automatic model_reset();
        m_state = 0;
        pend_to = -1;
        rst_at  = cyc + 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            kind = ev_kind.exists(cyc) ? ev_kind[cyc] : 0;
            if (pend_to == cyc) kind = 3;
            if (rst_at == cyc) begin
                kind = 0;
                exp_addr = '0;
                exp_dat  = '0;
            end
            if (kind == 1) begin
                exp_addr = ev_addr[cyc];
                exp_dat  = ev_dat[cyc];
            end else if (kind == 2) begin
                exp_addr = ev_addr[cyc];
            end
            chk("we", 32'(we), 32'(kind == 1));
            chk("re", 32'(re), 32'(kind == 2));
            chk("frame_err", 32'(frame_err), 32'(kind == 3));
            chk("addr", 32'(dma_dat_addr), 32'(exp_addr));
            chk("dat", 32'(dma_dat_r), 32'(exp_dat));
            if (kind == 1 || kind == 2) chk("busy_at_strobe", 32'(busy), 32'd0);
            if (we) n_we++;
            if (re) n_re++;
            if (frame_err) n_ferr++;
        end
    end

    initial begin
        int g;
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) tick();
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_re", 32'(re), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(dma_dat_addr), 32'd0);
        chk("rst_dat", 32'(dma_dat_r), 32'd0);
        reset = 1'b0;
        tick();
        chk_en = 1;
        repeat (4) tick();

        // Write frame
        send_byte(8'h99, 1);
        send_byte(8'hD7, 1);
        send_byte(8'h45, 1);
        repeat (2 * C) tick();
        chk("t1_addr", 32'(dma_dat_addr), 32'h19);
        chk("t1_dat", 32'(dma_dat_r), 32'h35D14);
        chk("t1_nwe", 32'(n_we), 32'd1);
        chk("t1_nre", 32'(n_re), 32'd0);
        chk("t1_nferr", 32'(n_ferr), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // Read frame
        send_byte(8'h19, 1);
        repeat (2 * C) tick();
        chk("t2_nre", 32'(n_re), 32'd1);
        chk("t2_addr", 32'(dma_dat_addr), 32'h19);
        chk("t2_dat", 32'(dma_dat_r), 32'h35D14);
        chk("t2_nwe", 32'(n_we), 32'd1);

        // Glitch shorter than half a bit
        g = cyc;
        uart_rxd = 1'b0;
        repeat (50) tick();
        chk("t3_busy_mid", 32'(busy), 32'd1);
        repeat (100 - (cyc - g)) tick();
        uart_rxd = 1'b1;
        repeat (H + 3) tick();
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_nferr", 32'(n_ferr), 32'd0);
        repeat (C) tick();

        // Framing error on second byte, then recovery
        send_byte(8'h99, 1);
        send_byte(8'hD7, 0);
        repeat (2 * C) tick();
        chk("t4_nferr", 32'(n_ferr), 32'd1);
        chk("t4_nwe", 32'(n_we), 32'd1);
        send_byte(8'h19, 1);
        repeat (2 * C) tick();
        chk("t4_nre", 32'(n_re), 32'd2);
        chk("t4_addr", 32'(dma_dat_addr), 32'h19);

        // Inter-byte timeout
        send_byte(8'h99, 1);
        send_byte(8'hD7, 1);
        repeat (T + 10) tick();
        chk("t5_nferr", 32'(n_ferr), 32'd2);
        chk("t5_busy", 32'(busy), 32'd0);
        send_byte(8'h19, 1);
        repeat (2 * C) tick();
        chk("t5_nre", 32'(n_re), 32'd3);
        chk("t5_nwe", 32'(n_we), 32'd1);

        // Reset in the middle of the second byte
        send_byte(8'h99, 1);
        uart_rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 4; i++) begin
            uart_rxd = (8'hD7 >> i) & 8'h01;
            repeat (C) tick();
        end
        model_reset();
        reset    = 1'b1;
        uart_rxd = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_addr", 32'(dma_dat_addr), 32'd0);
        chk("t6_dat", 32'(dma_dat_r), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        repeat (2 * C) tick();
        send_byte(8'h99, 1);
        send_byte(8'hD7, 1);
        send_byte(8'h45, 1);
        repeat (2 * C) tick();
        chk("t6_nwe", 32'(n_we), 32'd2);
        chk("t6_dat2", 32'(dma_dat_r), 32'h35D14);
        chk("t6_addr2", 32'(dma_dat_addr), 32'h19);
        chk("t6_nferr", 32'(n_ferr), 32'd2);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
